// File: rtl/lcd_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcd_scan_driver                                               |
// | Brief    : Free-running display timing master. Sweeps h/v counters,      |
// |            publishes active-area coordinates one cycle ahead to the      |
// |            renderers, and drives sync / DE / RGB565 to the panel with    |
// |            all panel outputs phase-aligned two cycles after the counters.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//
// Pipeline (t = cycle in which the counters hold a given position):
//   t   : h_cnt/v_cnt, combinational sync/active/frame terms
//   t+1 : pixel_req/xpos/ypos/frame_start, delayed hs/vs
//   t+2 : lcd_hs/lcd_vs/lcd_de, and lcd_rgb formed from the renderer's
//         registered pixel_data (which answers the t+1 coordinates)
//
// H_TOTAL and V_TOTAL must not exceed 2048 so both counters fit in 11 bits.

module lcd_scan_driver #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pixel_data,
  output logic        pixel_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        frame_start,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb
);

  // Derived timing constants
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;
  localparam int H_END   = H_START + H_DISP;
  localparam int V_END   = V_START + V_DISP;

  // Comparisons are done in a 12-bit domain so that an end-of-active bound
  // of exactly 2048 (zero front porch, maximum total) is still representable.
  localparam logic [11:0] H_LAST_C  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST_C  = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_C  = 12'(V_SYNC);
  localparam logic [11:0] H_START_C = 12'(H_START);
  localparam logic [11:0] V_START_C = 12'(V_START);
  localparam logic [11:0] H_END_C   = 12'(H_END);
  localparam logic [11:0] V_END_C   = 12'(V_END);

  // Offsets subtracted from the counters to form active-area coordinates
  localparam logic [10:0] H_OFFS = 11'(H_START);
  localparam logic [10:0] V_OFFS = 11'(V_START);

  // Scan counters
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;

  // Counter views in the 12-bit comparison domain
  logic [11:0] h_ext;
  logic [11:0] v_ext;

  // Combinational timing terms for the current counter position
  logic        h_last;
  logic        v_last;
  logic        hs_n;
  logic        vs_n;
  logic        h_act;
  logic        v_act;
  logic        act;
  logic        fs;
  logic [10:0] x_next;
  logic [10:0] y_next;

  // Stage-1 delay of the sync terms so they line up with the renderer latency
  logic        hs_d;
  logic        vs_d;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  // Decode sync, active-area and frame-start terms from the counters
  always_comb begin
    h_last = (h_ext == H_LAST_C);
    v_last = (v_ext == V_LAST_C);
    hs_n   = !(h_ext < H_SYNC_C);
    vs_n   = !(v_ext < V_SYNC_C);
    h_act  = (h_ext >= H_START_C) && (h_ext < H_END_C);
    v_act  = (v_ext >= V_START_C) && (v_ext < V_END_C);
    act    = h_act && v_act;
    fs     = (h_cnt == 11'd0) && (v_cnt == 11'd0);
    x_next = 11'd0;
    y_next = 11'd0;
    if (act) begin
      x_next = h_cnt - H_OFFS;
      y_next = v_cnt - V_OFFS;
    end
  end

  // Horizontal counter: 0..H_TOTAL-1, wrapping with no gap
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= 11'd0;
    end else if (h_last) begin
      h_cnt <= 11'd0;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Vertical counter: advances only when the line wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      v_cnt <= 11'd0;
    end else if (h_last) begin
      if (v_last) begin
        v_cnt <= 11'd0;
      end else begin
        v_cnt <= v_cnt + 11'd1;
      end
    end
  end

  // Stage 1: coordinates to the renderers plus delayed sync terms
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_req   <= 1'b0;
      pixel_xpos  <= 11'd0;
      pixel_ypos  <= 11'd0;
      frame_start <= 1'b0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
    end else begin
      pixel_req   <= act;
      pixel_xpos  <= x_next;
      pixel_ypos  <= y_next;
      frame_start <= fs;
      hs_d        <= hs_n;
      vs_d        <= vs_n;
    end
  end

  // Stage 2: panel sync and data-enable, aligned with the renderer's output
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_hs <= 1'b1;
      lcd_vs <= 1'b1;
      lcd_de <= 1'b0;
    end else begin
      lcd_hs <= hs_d;
      lcd_vs <= vs_d;
      lcd_de <= pixel_req;
    end
  end

  // The renderer's own output register is the stage-2 data capture: the
  // pixel_data present now answers the previous cycle's coordinates, which
  // is exactly the request that lcd_de is currently flagging. Gating by
  // lcd_de blanks the bus (and reset forces it to 0 because lcd_de is 0).
  assign lcd_rgb = lcd_de ? pixel_data : 16'h0000;

endmodule

`default_nettype wire

// File: tb/tb_lcd_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lcd_scan_driver                                            |
// | Brief    : Self-checking bench for lcd_scan_driver using a reduced       |
// |            timing (17 x 9 clocks per frame), a vector table of hand-     |
// |            computed observations, a registered model renderer and a      |
// |            streaming monitor for periods, widths and data alignment.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//
// Reduced timing: H = 4/3/8/2 (total 17, start 7), V = 2/2/4/1 (total 9,
// start 4), frame = 153 clocks. Sample index n counts falling edges after
// the last reset edge; the counters then sit at linear position n, stage 1
// shows position n-1 and the panel outputs show position n-2.

module tb_lcd_scan_driver;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic [15:0] pixel_data = 16'h0000;
  logic        pixel_req;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic        frame_start;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [15:0] lcd_rgb;

  lcd_scan_driver #(
    .H_SYNC (4), .H_BACK (3), .H_DISP (8), .H_FRONT(2),
    .V_SYNC (2), .V_BACK (2), .V_DISP (4), .V_FRONT(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_data (pixel_data),
    .pixel_req  (pixel_req),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .frame_start(frame_start),
    .lcd_hs     (lcd_hs),
    .lcd_vs     (lcd_vs),
    .lcd_de     (lcd_de),
    .lcd_rgb    (lcd_rgb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fs;
    logic        req;
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] rgb;
  } obs_t;

  typedef struct {
    int   n;
    obs_t exp;
  } vec_t;

  vec_t        vecs[$];
  int          checks     = 0;
  int          passed     = 0;
  int          n          = 0;
  logic        use_model  = 1'b0;
  logic [15:0] const_data = 16'hFFFF;
  logic        mon_en     = 1'b0;
  obs_t        reset_obs;

  function automatic logic [15:0] model(input logic [10:0] x, input logic [10:0] y);
    return {x[4:0], y[5:0], x[4:0]};
  endfunction

  function automatic obs_t mk(input logic fs, input logic req, input int x, input int y,
                              input logic hs, input logic vs, input logic de,
                              input logic [15:0] rgb);
    obs_t o;
    o.fs  = fs;
    o.req = req;
    o.x   = 11'(x);
    o.y   = 11'(y);
    o.hs  = hs;
    o.vs  = vs;
    o.de  = de;
    o.rgb = rgb;
    return o;
  endfunction

  function automatic obs_t cur();
    return mk(frame_start, pixel_req, int'(pixel_xpos), int'(pixel_ypos),
              lcd_hs, lcd_vs, lcd_de, lcd_rgb);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      while (n < vecs[i].n) step();
      check($sformatf("%s n=%0d {fs,req,x,y,hs,vs,de,rgb}", tag, vecs[i].n),
            64'(cur()), 64'(vecs[i].exp));
    end
  endtask

  // Model renderer: one register of latency from coordinates to data
  always @(posedge clk) pixel_data <= use_model ? model(pixel_xpos, pixel_ypos) : const_data;

  // Streaming monitor statistics
  int          mn = 0;
  logic        p_req = 1'b0, p_hs = 1'b1, p_vs = 1'b1;
  logic [10:0] p_x = 11'd0, p_y = 11'd0;
  logic [15:0] exp_rgb = 16'h0000;
  int last_fs = -1, last_hf = -1, last_vf = -1;
  int fs_cnt = 0, bad_fs = 0, hs_falls = 0, bad_hs_per = 0, bad_hs_w = 0;
  int vs_falls = 0, vs_rises = 0, bad_vs_w = 0, vs_align_bad = 0;
  int de_f0 = 0, de_f1 = 0, f800_cnt = 0;
  int blank_bad = 0, data_bad = 0, align_bad = 0, seq_bad = 0, zero_bad = 0;

  // Monitor samples 2 time units after each rising edge
  initial forever begin
    @(posedge clk);
    #2;
    if (mon_en) begin
      mn++;
      if (frame_start) begin
        fs_cnt++;
        if (last_fs >= 0 && mn - last_fs != 153) bad_fs++;
        last_fs = mn;
      end
      if (p_hs && !lcd_hs) begin
        hs_falls++;
        if (last_hf >= 0 && mn - last_hf != 17) bad_hs_per++;
        last_hf = mn;
      end
      if (!p_hs && lcd_hs && mn - last_hf != 4) bad_hs_w++;
      if (p_vs && !lcd_vs) begin
        vs_falls++;
        if (!(p_hs && !lcd_hs)) vs_align_bad++;
        last_vf = mn;
      end
      if (!p_vs && lcd_vs) begin
        vs_rises++;
        if (mn - last_vf != 34) bad_vs_w++;
      end
      if (lcd_de && mn >= 2 && mn < 155) de_f0++;
      if (lcd_de && mn >= 155 && mn < 308) de_f1++;
      if (lcd_de && mn >= 326 && mn < 479 && lcd_rgb == 16'hF800) f800_cnt++;
      if (!lcd_de && lcd_rgb != 16'h0000) blank_bad++;
      if (lcd_de != p_req) align_bad++;
      if (lcd_de && lcd_rgb != exp_rgb) data_bad++;
      if (pixel_req && p_req && (pixel_xpos != p_x + 11'd1 || pixel_ypos != p_y)) seq_bad++;
      if (!pixel_req && (pixel_xpos != 11'd0 || pixel_ypos != 11'd0)) zero_bad++;
      exp_rgb = use_model ? model(pixel_xpos, pixel_ypos) : const_data;
      p_req   = pixel_req;
      p_x     = pixel_xpos;
      p_y     = pixel_ypos;
      p_hs    = lcd_hs;
      p_vs    = lcd_vs;
    end
  end

  initial begin
    reset_obs = mk(0, 0, 0, 0, 1, 1, 0, 16'h0000);
    //                      fs req x  y  hs vs de rgb
    vecs.push_back('{0,   mk(0, 0, 0, 0, 1, 1, 0, 16'h0000)});
    vecs.push_back('{1,   mk(1, 0, 0, 0, 1, 1, 0, 16'h0000)});
    vecs.push_back('{2,   mk(0, 0, 0, 0, 0, 0, 0, 16'h0000)});
    vecs.push_back('{5,   mk(0, 0, 0, 0, 0, 0, 0, 16'h0000)});
    vecs.push_back('{6,   mk(0, 0, 0, 0, 1, 0, 0, 16'h0000)});
    vecs.push_back('{18,  mk(0, 0, 0, 0, 1, 0, 0, 16'h0000)});
    vecs.push_back('{19,  mk(0, 0, 0, 0, 0, 0, 0, 16'h0000)});
    vecs.push_back('{35,  mk(0, 0, 0, 0, 1, 0, 0, 16'h0000)});
    vecs.push_back('{36,  mk(0, 0, 0, 0, 0, 1, 0, 16'h0000)});
    vecs.push_back('{75,  mk(0, 0, 0, 0, 1, 1, 0, 16'h0000)});
    vecs.push_back('{76,  mk(0, 1, 0, 0, 1, 1, 0, 16'h0000)});
    vecs.push_back('{77,  mk(0, 1, 1, 0, 1, 1, 1, 16'h0000)});
    vecs.push_back('{80,  mk(0, 1, 4, 0, 1, 1, 1, 16'h1803)});
    vecs.push_back('{83,  mk(0, 1, 7, 0, 1, 1, 1, 16'h3006)});
    vecs.push_back('{84,  mk(0, 0, 0, 0, 1, 1, 1, 16'h3807)});
    vecs.push_back('{85,  mk(0, 0, 0, 0, 1, 1, 0, 16'h0000)});
    vecs.push_back('{94,  mk(0, 1, 1, 1, 1, 1, 1, 16'h0020)});
    vecs.push_back('{134, mk(0, 1, 7, 3, 1, 1, 1, 16'h3066)});
    vecs.push_back('{135, mk(0, 0, 0, 0, 1, 1, 1, 16'h3867)});
    vecs.push_back('{136, mk(0, 0, 0, 0, 1, 1, 0, 16'h0000)});
    vecs.push_back('{153, mk(0, 0, 0, 0, 1, 1, 0, 16'h0000)});
    vecs.push_back('{154, mk(1, 0, 0, 0, 1, 1, 0, 16'h0000)});
    vecs.push_back('{155, mk(0, 0, 0, 0, 0, 0, 0, 16'h0000)});

    // Reset held for 10 clocks with an all-ones renderer
    rst        = 1'b1;
    use_model  = 1'b0;
    const_data = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("reset hold %0d", i), 64'(cur()), 64'(reset_obs));
    end

    // Release reset; this sample is n = 0
    rst       = 1'b0;
    use_model = 1'b1;
    n         = 0;
    mon_en    = 1'b1;
    run_table("frame");

    // Constant red renderer during one full frame (switch in vertical blanking)
    while (n < 325) step();
    use_model  = 1'b0;
    const_data = 16'hF800;
    while (n < 480) step();
    mon_en = 1'b0;

    check("de cycles frame 0",     64'(de_f0),        64'(32));
    check("de cycles frame 1",     64'(de_f1),        64'(32));
    check("de F800 cycles",        64'(f800_cnt),     64'(32));
    check("frame_start count",     64'(fs_cnt),       64'(4));
    check("frame_start period",    64'(bad_fs),       64'(0));
    check("hs fall count",         64'(hs_falls),     64'(29));
    check("hs period",             64'(bad_hs_per),   64'(0));
    check("hs low width",          64'(bad_hs_w),     64'(0));
    check("vs fall count",         64'(vs_falls),     64'(4));
    check("vs rise count",         64'(vs_rises),     64'(3));
    check("vs low width",          64'(bad_vs_w),     64'(0));
    check("vs fall on hs fall",    64'(vs_align_bad), 64'(0));
    check("rgb zero when de=0",    64'(blank_bad),    64'(0));
    check("rgb vs model",          64'(data_bad),     64'(0));
    check("de follows pixel_req",  64'(align_bad),    64'(0));
    check("xpos sequence",         64'(seq_bad),      64'(0));
    check("coords zero when idle", 64'(zero_bad),     64'(0));

    // Mid-frame reset at counter position (h=10, v=5) of the fourth frame
    while (n < 554) step();
    check("pre-reset active", 64'(cur()), 64'(mk(0, 1, 2, 1, 1, 1, 1, 16'hF800)));
    rst       = 1'b1;
    use_model = 1'b1;
    step();
    check("mid-frame reset", 64'(cur()), 64'(reset_obs));
    rst = 1'b0;
    n   = 0;
    run_table("restart");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
